// File: rtl/usd_pulse_echo_sequencer.sv
// Pulse-echo sequencer: bipolar TX burst, range-gate delay, windowed ADC
// acquisition and PRF hold, plus a continuous-wave mode where TX and RX run
// together. Configuration arrives on the cmd/value/write register bus.
module usd_pulse_echo_sequencer #(
  parameter int CNT_W = 16,
  parameter int ADC_W = 14,
  parameter int CMD_W = 8
) (
  input  logic             clock,
  input  logic             nReset,
  input  logic             enable,
  input  logic [CMD_W-1:0] cmd,
  input  logic [CNT_W-1:0] value,
  input  logic             write,
  output logic             tx_pos,
  output logic             tx_neg,
  output logic             tx_pwdn,
  output logic             rx_pwdn,
  output logic             adc_clk,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             fifo_full,
  output logic             sample_valid,
  output logic [CNT_W-1:0] sample_data,
  output logic             overflow,
  output logic             busy
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [2:0] {IDLE, BURST, DELAY, ACQ, HOLD} state_t;

  state_t state, next_state;

  // shadow (bus-visible) configuration
  logic [CNT_W-1:0] sh_half, sh_ncyc, sh_prf, sh_dly, sh_nsamp, sh_div;
  logic             sh_cw, sh_swap;

  // active configuration, frozen for the duration of a frame
  logic [CNT_W-1:0] a_half, a_ncyc, a_prf, a_dly, a_nsamp, a_div;
  logic             a_cw, a_swap;

  // sequencing counters
  logic [CNT_W-1:0] frame_cnt, half_cnt, cyc_cnt, dly_cnt, div_cnt, samp_cnt;
  logic             phase, adc_ph;

  logic acq_run, half_end, burst_done, dly_done, div_end, fall, acq_done;
  logic hold_done, load_cfg, pulse_on, pos_raw, neg_raw, ctrl_clear;

  assign acq_run    = (state == ACQ) || ((state == BURST) && a_cw);
  assign half_end   = (half_cnt == a_half - ONE);
  assign burst_done = !a_cw && ((a_ncyc == '0) ||
                      (phase && half_end && (cyc_cnt == a_ncyc - ONE)));
  assign dly_done   = (dly_cnt == a_dly - ONE);
  assign div_end    = (div_cnt == a_div - ONE);
  assign fall       = acq_run && adc_ph && div_end && enable;
  assign acq_done   = fall && !a_cw && (samp_cnt == a_nsamp - ONE);
  // >= lets an over-long frame leave HOLD after a single cycle
  assign hold_done  = (frame_cnt >= a_prf - ONE);
  // config reloads on every frame start, not only from IDLE, so a mid-frame
  // write takes effect on the following frame
  assign load_cfg   = (next_state == BURST) && (state != BURST);
  assign ctrl_clear = write && (cmd == CMD_W'(7)) && value[2];

  // state register
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= next_state;
  end

  // next-state logic
  always_comb begin
    next_state = state;
    if (!enable) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:  next_state = BURST;
        BURST: if (burst_done) begin
                 if (a_dly != '0)        next_state = DELAY;
                 else if (a_nsamp != '0) next_state = ACQ;
                 else                    next_state = HOLD;
               end
        DELAY: if (dly_done) next_state = (a_nsamp != '0) ? ACQ : HOLD;
        ACQ:   if (acq_done) next_state = HOLD;
        HOLD:  if (hold_done) next_state = BURST;
        default: next_state = IDLE;
      endcase
    end
  end

  // output decode
  always_comb begin
    pulse_on = (state == BURST) && (a_cw || (a_ncyc != '0));
    pos_raw  = pulse_on && !phase;
    neg_raw  = pulse_on && phase;
    tx_pos   = a_swap ? neg_raw : pos_raw;
    tx_neg   = a_swap ? pos_raw : neg_raw;
    tx_pwdn  = (state != BURST);
    rx_pwdn  = !((state == DELAY) || (state == ACQ) || ((state == BURST) && a_cw));
    adc_clk  = acq_run && adc_ph;
    busy     = (state != IDLE);
  end

  // register bus writes into the shadow set
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      sh_half  <= CNT_W'(16);
      sh_ncyc  <= CNT_W'(4);
      sh_prf   <= CNT_W'(6400);
      sh_dly   <= '0;
      sh_nsamp <= CNT_W'(256);
      sh_div   <= ONE;
      sh_cw    <= 1'b0;
      sh_swap  <= 1'b0;
    end else if (write) begin
      case (cmd)
        CMD_W'(1): sh_half  <= value;
        CMD_W'(2): sh_ncyc  <= value;
        CMD_W'(3): sh_prf   <= value;
        CMD_W'(4): sh_dly   <= value;
        CMD_W'(5): sh_nsamp <= value;
        CMD_W'(6): sh_div   <= value;
        CMD_W'(7): begin
          sh_cw   <= value[0];
          sh_swap <= value[1];
        end
        default: ;
      endcase
    end
  end

  // active configuration snapshot at frame start
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      a_half  <= CNT_W'(16);
      a_ncyc  <= CNT_W'(4);
      a_prf   <= CNT_W'(6400);
      a_dly   <= '0;
      a_nsamp <= CNT_W'(256);
      a_div   <= ONE;
      a_cw    <= 1'b0;
      a_swap  <= 1'b0;
    end else if (load_cfg) begin
      a_half  <= (sh_half == '0) ? ONE : sh_half;
      a_ncyc  <= sh_ncyc;
      a_prf   <= sh_prf;
      a_dly   <= sh_dly;
      a_nsamp <= sh_nsamp;
      a_div   <= (sh_div == '0) ? ONE : sh_div;
      a_cw    <= sh_cw;
      a_swap  <= sh_swap;
    end
  end

  // frame counter: zero on burst entry, saturating
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset)                frame_cnt <= '0;
    else if (load_cfg)          frame_cnt <= '0;
    else if (frame_cnt != '1)   frame_cnt <= frame_cnt + ONE;
  end

  // burst half-period and cycle counters
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      half_cnt <= '0;
      cyc_cnt  <= '0;
      phase    <= 1'b0;
    end else if ((state == BURST) && enable) begin
      if (half_end) begin
        half_cnt <= '0;
        phase    <= ~phase;
        if (phase && !a_cw) cyc_cnt <= cyc_cnt + ONE;
      end else begin
        half_cnt <= half_cnt + ONE;
      end
    end else begin
      half_cnt <= '0;
      cyc_cnt  <= '0;
      phase    <= 1'b0;
    end
  end

  // range-gate delay counter
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset)                          dly_cnt <= '0;
    else if ((state == DELAY) && enable)  dly_cnt <= dly_cnt + ONE;
    else                                  dly_cnt <= '0;
  end

  // ADC clock divider and sample counter; adc_clk starts in its high phase
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      div_cnt  <= '0;
      adc_ph   <= 1'b1;
      samp_cnt <= '0;
    end else if (acq_run && enable) begin
      if (div_end) begin
        div_cnt <= '0;
        adc_ph  <= ~adc_ph;
        if (adc_ph && !a_cw) samp_cnt <= samp_cnt + ONE;
      end else begin
        div_cnt <= div_cnt + ONE;
      end
    end else begin
      div_cnt  <= '0;
      adc_ph   <= 1'b1;
      samp_cnt <= '0;
    end
  end

  // sample capture on the adc_clk falling edge, FIFO strobe and sticky overflow
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      sample_valid <= 1'b0;
      sample_data  <= '0;
      overflow     <= 1'b0;
    end else begin
      sample_valid <= fall && !fifo_full;
      if (fall) sample_data <= CNT_W'($signed(adc_data));
      if (fall && fifo_full) overflow <= 1'b1;
      else if (ctrl_clear)   overflow <= 1'b0;
    end
  end

endmodule
